qoa_spi_host: RTL

Host-side SPI mode-0 initiator for the QOA decoder chip. It is used in the FPGA test harness and the system bench.
- Write command: frames one QOA stream byte out on MOSI.
- Read command: reads one 16-bit decoded sample back on MISO.
It generates SCK, CS_n and the inter-frame gaps that the chip's slave interface needs:
- a CS-high SCK pulse so the slave preloads its TX MSB;
- a CS-high gap long enough for the slave's two-flop RX_done synchroniser.

---
 rtl/qoa_spi_pkg.sv | 22 ++
 rtl/qoa_spi_sckgen.sv | 46 ++++
 rtl/qoa_spi_host.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/qoa_spi_pkg.sv
// qoa_spi_pkg: shared types and constants for the QOA SPI host.
//   state_t    - host FSM states
//   WRITE_BITS - bits per write frame (one stream byte)
//   READ_BITS  - bits per read frame (one decoded sample)
//   CMD_WRITE / CMD_READ - encoding of cmd_read
package qoa_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRELOAD,
        SETUP,
        SHIFT,
        GAP
    } state_t;

    localparam int WRITE_BITS = 8;
    localparam int READ_BITS  = 16;

    localparam logic CMD_WRITE = 1'b0;
    localparam logic CMD_READ  = 1'b1;

endpackage

// File: rtl/qoa_spi_sckgen.sv
// qoa_spi_sckgen: SCK half-period generator.
//   sclk, rst_n : clock, synchronous active-low reset
//   en          : enable from the FSM; when low sck is forced to 0 and the counter clears
//   rise_req    : start a bit period (sck goes 1 at this edge)
//   sck         : registered SPI clock
//   fall        : sck goes 1->0 at this edge
//   low_done    : the low half of the current bit ends at this edge
// The generator never raises sck on its own; the FSM decides whether another
// bit follows, so the last low phase simply ends with sck staying low.
module qoa_spi_sckgen #(
    parameter int CLK_DIV = 4
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic en,
    input  logic rise_req,
    output logic sck,
    output logic fall,
    output logic low_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          last;

    assign last     = (cnt == CW'(CLK_DIV - 1));
    assign fall     = sck & last;
    assign low_done = ~sck & last;

    always_ff @(posedge sclk) begin
        if (!rst_n || !en) begin
            sck <= 1'b0;
            cnt <= '0;
        end else if (rise_req) begin
            sck <= 1'b1;
            cnt <= '0;
        end else if (last) begin
            sck <= 1'b0;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/qoa_spi_host.sv
// qoa_spi_host: SPI mode-0 initiator for the QOA decoder chip.
//   sclk, rst_n          : clock, synchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake (ready only in IDLE)
//   cmd_read, cmd_wdata  : 0 = write cmd_wdata byte, 1 = read a 16-bit sample
//   rsp_valid, rsp_data  : one-cycle pulse with the sample read, data held
//   busy                 : any state other than IDLE
//   spi_sck/cs_n/mosi    : registered SPI outputs
//   spi_miso             : chip data, sampled on the SCK rising edge
// A read starts with one SCK pulse while CS_n is high so the chip preloads its
// TX MSB; every frame ends with GAP_CYCLES of CS_n high so the chip's two-flop
// RX_done synchroniser can see it.
module qoa_spi_host
    import qoa_spi_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 2,
    parameter int GAP_CYCLES = 16
) (
    input  logic        sclk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_read,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        busy,
    output logic        spi_sck,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    state_t      state;
    logic        is_read;
    logic [7:0]  tx_sh;
    logic [15:0] rx_sh;
    logic [4:0]  bit_cnt;
    logic [15:0] tmr;

    logic        cs_n_q;
    logic        mosi_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_data_q;
    logic        rdy_q;
    logic        busy_q;

    logic        sck;
    logic        fall;
    logic        low_done;
    logic        rise_req;
    logic        sck_en;
    logic        accept;
    logic        setup_done;
    logic        last_bit;

    assign accept     = cmd_valid & rdy_q & (state == IDLE);
    assign setup_done = (state == SETUP) && (tmr == 16'(CS_SETUP - 1));
    assign last_bit   = (bit_cnt == (is_read ? 5'(READ_BITS) : 5'(WRITE_BITS)));

    // Rising edges: the preload pulse at read accept, the first data bit at
    // the end of SETUP, and each following bit once the previous low phase ends.
    assign rise_req = (accept & (cmd_read == CMD_READ))
                    | setup_done
                    | ((state == SHIFT) & low_done & ~last_bit);

    assign sck_en = rise_req | (state == PRELOAD) | (state == SHIFT);

    qoa_spi_sckgen #(
        .CLK_DIV (CLK_DIV)
    ) u_sckgen (
        .sclk     (sclk),
        .rst_n    (rst_n),
        .en       (sck_en),
        .rise_req (rise_req),
        .sck      (sck),
        .fall     (fall),
        .low_done (low_done)
    );

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state       <= IDLE;
            is_read     <= 1'b0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            bit_cnt     <= '0;
            tmr         <= '0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        is_read <= cmd_read;
                        tx_sh   <= (cmd_read == CMD_READ) ? 8'h00 : cmd_wdata;
                        bit_cnt <= '0;
                        tmr     <= '0;
                        rdy_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        if (cmd_read == CMD_READ) begin
                            state <= PRELOAD;
                        end else begin
                            state  <= SETUP;
                            cs_n_q <= 1'b0;
                            mosi_q <= cmd_wdata[7];
                        end
                    end else begin
                        rdy_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end

                PRELOAD: begin
                    if (low_done) begin
                        state  <= SETUP;
                        cs_n_q <= 1'b0;
                        mosi_q <= tx_sh[7];
                        tmr    <= '0;
                    end
                end

                SETUP: begin
                    if (setup_done) begin
                        state <= SHIFT;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr + 16'd1;
                    end
                end

                SHIFT: begin
                    // tx_sh back-fills with zeros, so MOSI drops to 0 after the last bit.
                    if (fall) begin
                        bit_cnt <= bit_cnt + 5'd1;
                        mosi_q  <= tx_sh[6];
                        tx_sh   <= {tx_sh[6:0], 1'b0};
                    end
                    if (low_done && last_bit) begin
                        state  <= GAP;
                        cs_n_q <= 1'b1;
                        mosi_q <= 1'b0;
                        tmr    <= '0;
                        if (is_read) begin
                            rsp_data_q  <= rx_sh;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end

                GAP: begin
                    if (tmr == 16'(GAP_CYCLES - 1)) begin
                        state  <= IDLE;
                        rdy_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        tmr <= tmr + 16'd1;
                    end
                end

                default: state <= IDLE;
            endcase

            // MISO is captured on every data rising edge (not the preload pulse).
            if (rise_req && (state != IDLE)) begin
                rx_sh <= {rx_sh[14:0], spi_miso};
            end
        end
    end

    assign cmd_ready = rdy_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign spi_sck   = sck;
    assign spi_cs_n  = cs_n_q;
    assign spi_mosi  = mosi_q;

endmodule
